// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer
// Control sequencer for the MAC units of one DCT block. It counts TAPS
// accepted samples per vector, drives the MAC clear/enable strobes and the
// result-register load, and presents finished results with a valid/ready
// handshake. A row counter tracks the position inside the 8x8 block.
// TAPS must be at least 2, and IDX_W must be wide enough to hold TAPS-1.

module dct_mac_sequencer #(
    parameter int TAPS  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             mac_clr_o,
    output logic             mac_ena_o,
    output logic [IDX_W-1:0] tap_idx_o,
    output logic             res_load_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic [IDX_W-1:0] row_idx_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] tap_q, tap_d;
    logic [IDX_W-1:0] rcnt_q, rcnt_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             in_ready;
    logic             acc;
    logic             res_load;

    // State register: every piece of sequencing state, synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            rcnt_q      <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            rcnt_q      <= rcnt_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic: tap stepping, DRAIN exit, row counter, result slot.
    // NOTE: every target gets a hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        rcnt_d      = rcnt_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    tap_d   = ONE;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (acc) begin
                    if (tap_q == LAST_IDX) begin
                        tap_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        tap_d = tap_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (res_load) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tap_d   = '0;
            end
        endcase

        // Consuming the held result frees the slot; a load in the same cycle
        // refills it, so a simultaneous consume and load leaves no bubble.
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (res_load) begin
            out_valid_d = 1'b1;
            row_d       = rcnt_q;
            out_last_d  = (rcnt_q == LAST_IDX);
            rcnt_d      = (rcnt_q == LAST_IDX) ? '0 : rcnt_q + ONE;
        end
    end

    // Output logic: handshake, MAC strobes and result-register load enable.
    always_comb begin
        in_ready = ena_i && (state_q == S_IDLE || state_q == S_ACC);
        acc      = in_valid_i && in_ready;
        // DRAIN may only load when the result slot is free or being emptied.
        res_load = (state_q == S_DRAIN) && ena_i && !(out_valid_q && !out_ready_i);
    end

    assign in_ready_o  = in_ready;
    assign mac_ena_o   = acc;
    assign mac_clr_o   = acc && (state_q == S_IDLE);
    assign res_load_o  = res_load;
    assign tap_idx_o   = tap_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign row_idx_o   = row_q;
    assign busy_o      = (state_q != S_IDLE) || out_valid_q;

endmodule
